// File: rtl/fx2_stream_out_reader_pkg.sv
// Shared FX2 slave-FIFO definitions: reader state encoding and endpoint addresses.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fx2_stream_out_reader_pkg;

    // Reader states: idle, one-cycle bus turnaround, active read
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_TURN = 2'b01,
        ST_READ = 2'b10
    } rd_state_t;

    // FIFOADR values; EP6 is used by the stream-in controller on the same pins
    localparam logic [1:0] EP2 = 2'b00;
    localparam logic [1:0] EP6 = 2'b10;

    // Level counter width for a buffer of the given depth (0..depth inclusive)
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fx2_stream_out_reader_if.sv
// FX2 EP2 pins plus downstream byte stream and status, bundled for the reader.
// Latency: n/a (wiring only).
// Backpressure: m_ready from the consumer; flaga_n/enable gate the FX2 side.
interface fx2_stream_out_reader_if
    import fx2_stream_out_reader_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int CW = level_width(DEPTH);

    logic          enable;
    logic          flaga_n;
    logic [7:0]    data_in;
    logic [1:0]    faddr;
    logic          sloe_n;
    logic          slrd_n;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic [15:0]   byte_count;
    logic [CW-1:0] fifo_level;

    // The reader block itself
    modport master (
        input  enable, flaga_n, data_in, m_ready,
        output faddr, sloe_n, slrd_n, m_data, m_valid, byte_count, fifo_level
    );

    // The FX2 / consumer / control side
    modport slave (
        output enable, flaga_n, data_in, m_ready,
        input  faddr, sloe_n, slrd_n, m_data, m_valid, byte_count, fifo_level
    );

endinterface

// File: rtl/fx2_stream_out_reader_sync_byte_fifo.sv
// Single-clock byte FIFO with level count; dout shows the head slot combinationally.
// Latency: a byte pushed at edge N is on dout with empty=0 after edge N.
// Backpressure: push ignored when full, pop ignored when empty; full/empty from registered level.
module sync_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == CW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage; cleared on reset so the head byte reads 00 while empty after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fx2_stream_out_reader.sv
// Drains FX2 EP2 OUT via SLOE/SLRD into a local byte FIFO and streams it downstream.
// Latency: first strobe 2 cycles after qualifying in idle; captured byte visible next cycle.
// Backpressure: strobe drops combinationally on !enable, !flaga_n or buffer full; m_ready pops.
module fx2_stream_out_reader
    import fx2_stream_out_reader_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter logic [1:0] EP_ADDR = EP2
) (
    input  logic                   clk,
    input  logic                   reset,
    fx2_stream_out_reader_if.master bus
);
    localparam int CW = level_width(DEPTH);

    rd_state_t state_q;
    rd_state_t state_d;
    logic      full;
    logic      empty;
    logic      rd_en;
    logic      pop;
    logic [15:0] byte_count_q;

    // Read only from the READ state with the endpoint non-empty and local space present
    assign rd_en = (state_q == ST_READ) & bus.enable & bus.flaga_n & ~full;
    assign pop   = bus.m_ready & ~empty;

    assign bus.faddr      = EP_ADDR;
    assign bus.sloe_n     = (state_q == ST_IDLE);
    assign bus.slrd_n     = ~rd_en;
    assign bus.m_valid    = ~empty;
    assign bus.byte_count = byte_count_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: every entry to READ passes through one turnaround cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.enable & bus.flaga_n & ~full) state_d = ST_TURN;
            ST_TURN: state_d = ST_READ;
            ST_READ: if (~bus.enable | ~bus.flaga_n | full) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Running count of bytes taken from the FX2, wrapping at 16 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      byte_count_q <= 16'h0000;
        else if (rd_en) byte_count_q <= byte_count_q + 16'd1;
    end

    sync_byte_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_en),
        .din   (bus.data_in),
        .pop   (pop),
        .dout  (bus.m_data),
        .full  (full),
        .empty (empty),
        .level (bus.fifo_level)
    );

endmodule

// File: tb/tb_fx2_stream_out_reader.sv
// Randomized bench for the EP2 stream-out reader against a queue-based FX2 reader model.
// Latency: n/a.
// Backpressure: random m_ready and flaga_n exercise both sides.
module tb_fx2_stream_out_reader;
    import fx2_stream_out_reader_pkg::*;

    localparam int DEPTH = 16;

    logic clk;
    logic reset;

    fx2_stream_out_reader_if #(.DEPTH(DEPTH)) bus ();

    fx2_stream_out_reader #(
        .DEPTH   (DEPTH),
        .EP_ADDR (EP2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: buffered bytes, cycles since engaging the bus (0 idle, 1 turnaround, 2 reading)
    logic [7:0]  mq [$];
    int          run;
    logic [15:0] mcnt;
    int          nreads;
    bit          do_chk;
    bit          inc_mode;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        run    = 0;
        mcnt   = 16'h0000;
        nreads = 0;
    endtask

    // Called just after a negedge with inputs settled; compares, clocks, advances model
    task automatic step();
        bit full_m;
        bit exp_rd;
        bit en;
        bit fl;
        #1;
        en     = bus.enable;
        fl     = bus.flaga_n;
        full_m = (mq.size() == DEPTH);
        exp_rd = (run == 2) && en && fl && !full_m;
        if (do_chk) begin
            check_eq("sloe_n", bus.sloe_n, (run == 0));
            check_eq("slrd_n", bus.slrd_n, !exp_rd);
            check_eq("m_valid", bus.m_valid, (mq.size() != 0));
            if (mq.size() != 0) check_eq("m_data", bus.m_data, mq[0]);
            check_eq("fifo_level", bus.fifo_level, mq.size());
            check_eq("byte_count", bus.byte_count, mcnt);
            check_eq("faddr", bus.faddr, EP2);
        end
        @(posedge clk);
        if (mq.size() != 0 && bus.m_ready) void'(mq.pop_front());
        if (exp_rd) begin
            mq.push_back(bus.data_in);
            mcnt = mcnt + 16'd1;
            nreads++;
        end
        case (run)
            0:       if (en && fl && !full_m) run = 1;
            1:       run = 2;
            default: if (!exp_rd) run = 0;
        endcase
        @(negedge clk);
        if (inc_mode && exp_rd) bus.data_in = bus.data_in + 8'd1;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_sloe_n", bus.sloe_n, 1'b1);
        check_eq("rst_slrd_n", bus.slrd_n, 1'b1);
        check_eq("rst_m_valid", bus.m_valid, 1'b0);
        check_eq("rst_m_data", bus.m_data, 8'h00);
        check_eq("rst_level", bus.fifo_level, 0);
        check_eq("rst_count", bus.byte_count, 16'h0000);
        check_eq("rst_faddr", bus.faddr, EP2);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.flaga_n = 1'b0;
        bus.data_in = 8'h00;
        bus.m_ready = 1'b0;
        do_chk      = 1'b1;
        inc_mode    = 1'b0;
        model_clear();
        @(negedge clk);
        apply_reset();

        // Stream incrementing bytes, back up the buffer, then reset mid-stream
        inc_mode    = 1'b1;
        bus.data_in = 8'h00;
        bus.enable  = 1'b1;
        bus.flaga_n = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_eq("pre_rst_level", bus.fifo_level, mq.size());
        apply_reset();
        inc_mode = 1'b0;

        // Fill to full with no consumer, then free one slot
        bus.m_ready = 1'b0;
        for (int i = 0; i < 25; i++) begin
            bus.data_in = 8'($urandom);
            step();
        end
        check_eq("fill_level", bus.fifo_level, DEPTH);
        check_eq("fill_count", bus.byte_count, 16'd16);
        check_eq("fill_idle", bus.sloe_n, 1'b1);
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_eq("refill_count", bus.byte_count, 16'd17);

        // Flag drop after five reads
        apply_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 20 && nreads < 5; i++) begin
            bus.data_in = 8'($urandom);
            step();
        end
        bus.flaga_n = 1'b0;
        step();
        check_eq("drop_count", bus.byte_count, 16'd5);
        check_eq("drop_idle", bus.sloe_n, 1'b1);
        bus.flaga_n = 1'b1;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 20 && mq.size() < 3; i++) begin
            bus.data_in = 8'($urandom);
            step();
        end
        check_eq("pp_pre_level", bus.fifo_level, 3);
        bus.m_ready = 1'b1;
        bus.data_in = 8'($urandom);
        step();
        check_eq("pp_level", bus.fifo_level, 3);
        for (int i = 0; i < 6; i++) step();

        // Enable toggling every three cycles with random consumer stalls
        apply_reset();
        for (int i = 0; i < 150; i++) begin
            if (i % 3 == 0) bus.enable = ~bus.enable;
            bus.data_in = 8'($urandom);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Fully random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.enable  = ($urandom_range(0, 7) != 0);
            bus.flaga_n = ($urandom_range(0, 4) != 0);
            bus.m_ready = ($urandom_range(0, 2) != 0);
            bus.data_in = 8'($urandom);
            step();
        end

        // Long stream of 65537 bytes to wrap the byte counter
        apply_reset();
        bus.enable  = 1'b1;
        bus.flaga_n = 1'b1;
        bus.m_ready = 1'b1;
        do_chk      = 1'b0;
        for (int i = 0; i < 66000 && nreads < 65537; i++) begin
            bus.data_in = 8'(i);
            step();
        end
        bus.enable = 1'b0;
        do_chk     = 1'b1;
        step();
        check_eq("wrap_count", bus.byte_count, 16'd1);
        check_eq("wrap_reads", nreads, 65537);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
